ddr_cmd_scheduler: RTL and testbench

- Shares the DDR command/address bus between two requesters: the write path and the read path.
- Arbitrates round-robin between them and keeps an open-row table for 8 banks (open-page policy).
- Sequences PRECHARGE/ACTIVATE/READ/WRITE with tRP, tRCD, tWR and tCCD spacing.
- Sits between the command-level Write/Read state machines and the DRAM pins.

---
 rtl/ddr_cmd_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: round-robin arbitration between a write and a read
// requester, an open-row table for 8 banks (open-page policy), and sequencing
// of PRECHARGE / ACTIVATE / READ / WRITE with tRP, tRCD, tWR and tCCD spacing.
// All DRAM pin outputs and grants are registered.
module ddr_cmd_scheduler #(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_WR  = 4,
  parameter int T_CCD = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        wr_req,
  input  logic [14:0] wr_row,
  input  logic [9:0]  wr_col,
  input  logic [2:0]  wr_ba,
  input  logic        wr_ap,
  output logic        wr_gnt,
  input  logic        rd_req,
  input  logic [14:0] rd_row,
  input  logic [9:0]  rd_col,
  input  logic [2:0]  rd_ba,
  input  logic        rd_ap,
  output logic        rd_gnt,
  output logic        CS_n,
  output logic        RAS_n,
  output logic        CAS_n,
  output logic        WE_n,
  output logic [14:0] Addr_out,
  output logic [2:0]  BA_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_DONE
  } state_e;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  // Counter must hold the longest single wait (recovery plus auto-precharge).
  localparam int CNT_MAX = ((T_WR > T_CCD) ? T_WR : T_CCD) + T_RP + T_RCD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_rd_q, last_rd_d;   // 1: read was served last
  logic [14:0]       row_q, row_d;
  logic [9:0]        col_q, col_d;
  logic [2:0]        ba_q, ba_d;
  logic              ap_q, ap_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        open_q, open_d;
  logic [7:0][14:0]  row_tbl_q, row_tbl_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [14:0]       addr_q, addr_d;
  logic [2:0]        bank_out_q, bank_out_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              busy_q, busy_d;

  logic              grant_wr_s, grant_rd_s;
  logic [14:0]       sel_row_s;
  logic [9:0]        sel_col_s;
  logic [2:0]        sel_ba_s;
  logic              sel_ap_s;

  // Arbitration, next-state decision, command generation and table updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_rd_d  = last_rd_q;
    row_d      = row_q;
    col_d      = col_q;
    ba_d       = ba_q;
    ap_d       = ap_q;
    is_wr_d    = is_wr_q;
    open_d     = open_q;
    row_tbl_d  = row_tbl_q;
    cmd_d      = CMD_NOP;
    addr_d     = addr_q;
    bank_out_d = bank_out_q;
    wr_gnt_d   = 1'b0;
    rd_gnt_d   = 1'b0;

    // Round-robin: on contention the requester not served last wins.
    grant_wr_s = wr_req & (~rd_req | last_rd_q);
    grant_rd_s = rd_req & (~wr_req | ~last_rd_q);
    sel_row_s  = grant_wr_s ? wr_row : rd_row;
    sel_col_s  = grant_wr_s ? wr_col : rd_col;
    sel_ba_s   = grant_wr_s ? wr_ba  : rd_ba;
    sel_ap_s   = grant_wr_s ? wr_ap  : rd_ap;

    case (state_q)
      S_IDLE: begin
        if (grant_wr_s || grant_rd_s) begin
          wr_gnt_d  = grant_wr_s;
          rd_gnt_d  = grant_rd_s;
          last_rd_d = grant_rd_s;
          row_d     = sel_row_s;
          col_d     = sel_col_s;
          ba_d      = sel_ba_s;
          ap_d      = sel_ap_s;
          is_wr_d   = grant_wr_s;
          if (open_q[sel_ba_s]) begin
            state_d = (row_tbl_q[sel_ba_s] == sel_row_s) ? S_CAS : S_PRE;
          end else begin
            state_d = S_ACT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        cmd_d          = CMD_PRE;
        addr_d         = 15'h0000;     // A10 low: single-bank precharge
        bank_out_d     = ba_q;
        open_d[ba_q]   = 1'b0;
        if (T_RP > 1) begin
          state_d = S_WAIT_RP;
          cnt_d   = CNT_W'(T_RP - 1);
        end else begin
          state_d = S_ACT;
        end
      end
      S_WAIT_RP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACT: begin
        cmd_d           = CMD_ACT;
        addr_d          = row_q;
        bank_out_d      = ba_q;
        open_d[ba_q]    = 1'b1;
        row_tbl_d[ba_q] = row_q;
        if (T_RCD > 1) begin
          state_d = S_WAIT_RCD;
          cnt_d   = CNT_W'(T_RCD - 1);
        end else begin
          state_d = S_CAS;
        end
      end
      S_WAIT_RCD: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_CAS;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CAS: begin
        cmd_d      = is_wr_q ? CMD_WR : CMD_RD;
        addr_d     = {4'b0000, ap_q, col_q};
        bank_out_d = ba_q;
        state_d    = S_WAIT_DONE;
        // Auto-precharge closes the bank and extends the recovery by tRP.
        if (ap_q) begin
          open_d[ba_q] = 1'b0;
          cnt_d = is_wr_q ? CNT_W'(T_WR + T_RP) : CNT_W'(T_CCD + T_RP);
        end else begin
          cnt_d = is_wr_q ? CNT_W'(T_WR) : CNT_W'(T_CCD);
        end
      end
      S_WAIT_DONE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, bank table and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_rd_q  <= 1'b1;
      row_q      <= 15'h0000;
      col_q      <= 10'h000;
      ba_q       <= 3'd0;
      ap_q       <= 1'b0;
      is_wr_q    <= 1'b0;
      open_q     <= 8'h00;
      row_tbl_q  <= '0;
      cmd_q      <= CMD_NOP;
      addr_q     <= 15'h0000;
      bank_out_q <= 3'd0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_rd_q  <= last_rd_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ba_q       <= ba_d;
      ap_q       <= ap_d;
      is_wr_q    <= is_wr_d;
      open_q     <= open_d;
      row_tbl_q  <= row_tbl_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      bank_out_q <= bank_out_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      busy_q     <= busy_d;
    end
  end

  assign {CS_n, RAS_n, CAS_n, WE_n} = cmd_q;
  assign Addr_out = addr_q;
  assign BA_out   = bank_out_q;
  assign wr_gnt   = wr_gnt_q;
  assign rd_gnt   = rd_gnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Testbench for ddr_cmd_scheduler: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level model of the scheduler.
module tb_ddr_cmd_scheduler;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_WR  = 4;
  localparam int T_CCD = 2;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [14:0] wr_row = 15'h0, rd_row = 15'h0;
  logic [9:0]  wr_col = 10'h0, rd_col = 10'h0;
  logic [2:0]  wr_ba = 3'd0, rd_ba = 3'd0;
  logic        wr_ap = 1'b0, rd_ap = 1'b0;
  logic        wr_gnt, rd_gnt, CS_n, RAS_n, CAS_n, WE_n, busy;
  logic [14:0] Addr_out;
  logic [2:0]  BA_out;

  ddr_cmd_scheduler #(.T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR), .T_CCD(T_CCD)) dut (
    .clk(clk), .areset(areset),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_ba(wr_ba), .wr_ap(wr_ap), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_ba(rd_ba), .rd_ap(rd_ap), .rd_gnt(rd_gnt),
    .CS_n(CS_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .Addr_out(Addr_out), .BA_out(BA_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Trace of sampled outputs, index 0 = first sample after stimulus is set.
  logic [3:0]  tr_cmd [32];
  logic [14:0] tr_addr[32];
  logic [2:0]  tr_ba  [32];
  logic        tr_busy[32];
  logic        tr_wg  [32];
  logic        tr_rg  [32];
  int          n_tr;

  task automatic set_wr(input logic [2:0] ba, input logic [14:0] row, input logic [9:0] col, input logic ap);
    wr_req = 1'b1; wr_ba = ba; wr_row = row; wr_col = col; wr_ap = ap;
  endtask

  task automatic set_rd(input logic [2:0] ba, input logic [14:0] row, input logic [9:0] col, input logic ap);
    rd_req = 1'b1; rd_ba = ba; rd_row = row; rd_col = col; rd_ap = ap;
  endtask

  task automatic apply_reset();
    wr_req = 1'b0; rd_req = 1'b0; areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    n_tr = 0;
  endtask

  // Sample n cycles on the falling edge; drop a request once it is granted.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (n_tr < 32) begin
        tr_cmd[n_tr] = {CS_n, RAS_n, CAS_n, WE_n}; tr_addr[n_tr] = Addr_out;
        tr_ba[n_tr] = BA_out; tr_busy[n_tr] = busy; tr_wg[n_tr] = wr_gnt; tr_rg[n_tr] = rd_gnt;
      end
      n_tr++;
      if (wr_gnt) wr_req = 1'b0;
      if (rd_gnt) rd_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    set_wr(3'd1, 15'h0100, 10'h001, 1'b0);
    capture(2);
    areset = 1'b1;
    @(negedge clk);
    checks++; if ({CS_n, RAS_n, CAS_n, WE_n} !== C_NOP) begin errors++; $display("FAIL reset_cmd: got %b want %b", {CS_n, RAS_n, CAS_n, WE_n}, C_NOP); end
    checks++; if (Addr_out !== 15'h0 || BA_out !== 3'd0) begin errors++; $display("FAIL reset_addr: got %h/%0d want 0/0", Addr_out, BA_out); end
    checks++; if ({busy, wr_gnt, rd_gnt} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, wr_gnt, rd_gnt}); end
    areset = 1'b0;
    n_tr = 0;
    capture(6);
    checks++; if (tr_cmd[3] !== C_NOP || tr_busy[3] !== 1'b0) begin errors++; $display("FAIL reset_quiet: got %b/%b want %b/0", tr_cmd[3], tr_busy[3], C_NOP); end
  endtask

  task automatic test_single_write();
    apply_reset();
    set_wr(3'd3, 15'h1A2B, 10'h3C4, 1'b0);
    capture(9);
    checks++; if (tr_wg[0] !== 1'b1 || tr_rg[0] !== 1'b0) begin errors++; $display("FAIL wr_gnt: got %b%b want 10", tr_wg[0], tr_rg[0]); end
    checks++; if (tr_cmd[1] !== C_ACT || tr_addr[1] !== 15'h1A2B || tr_ba[1] !== 3'd3) begin errors++; $display("FAIL wr_act: got %b %h %0d want %b 1a2b 3", tr_cmd[1], tr_addr[1], tr_ba[1], C_ACT); end
    checks++; if (tr_cmd[2] !== C_NOP || tr_cmd[3] !== C_NOP || tr_addr[3] !== 15'h1A2B) begin errors++; $display("FAIL wr_rcd_gap: got %b %b %h want NOP NOP 1a2b", tr_cmd[2], tr_cmd[3], tr_addr[3]); end
    checks++; if (tr_cmd[4] !== C_WR || tr_addr[4] !== 15'h03C4 || tr_ba[4] !== 3'd3) begin errors++; $display("FAIL wr_cas: got %b %h %0d want %b 03c4 3", tr_cmd[4], tr_addr[4], tr_ba[4], C_WR); end
    checks++; if (tr_busy[7] !== 1'b1 || tr_busy[8] !== 1'b0) begin errors++; $display("FAIL wr_twr: got busy %b%b want 10", tr_busy[7], tr_busy[8]); end
  endtask

  task automatic test_row_hit();
    n_tr = 0;
    set_wr(3'd3, 15'h1A2B, 10'h010, 1'b0);
    capture(6);
    checks++; if (tr_wg[0] !== 1'b1) begin errors++; $display("FAIL hit_gnt: got %b want 1", tr_wg[0]); end
    checks++; if (tr_cmd[1] !== C_WR || tr_addr[1] !== 15'h0010 || tr_ba[1] !== 3'd3) begin errors++; $display("FAIL hit_cas: got %b %h %0d want %b 0010 3", tr_cmd[1], tr_addr[1], tr_ba[1], C_WR); end
    checks++; if (tr_busy[4] !== 1'b1 || tr_busy[5] !== 1'b0) begin errors++; $display("FAIL hit_done: got busy %b%b want 10", tr_busy[4], tr_busy[5]); end
  endtask

  task automatic test_row_miss();
    n_tr = 0;
    set_rd(3'd3, 15'h5D6E, 10'h123, 1'b0);
    capture(10);
    checks++; if (tr_rg[0] !== 1'b1 || tr_wg[0] !== 1'b0) begin errors++; $display("FAIL miss_gnt: got %b%b want 01", tr_wg[0], tr_rg[0]); end
    checks++; if (tr_cmd[1] !== C_PRE || tr_ba[1] !== 3'd3 || tr_addr[1][10] !== 1'b0) begin errors++; $display("FAIL miss_pre: got %b %0d a10=%b want %b 3 0", tr_cmd[1], tr_ba[1], tr_addr[1][10], C_PRE); end
    checks++; if (tr_cmd[2] !== C_NOP || tr_cmd[3] !== C_NOP) begin errors++; $display("FAIL miss_trp_gap: got %b %b want NOP", tr_cmd[2], tr_cmd[3]); end
    checks++; if (tr_cmd[4] !== C_ACT || tr_addr[4] !== 15'h5D6E || tr_ba[4] !== 3'd3) begin errors++; $display("FAIL miss_act: got %b %h %0d want %b 5d6e 3", tr_cmd[4], tr_addr[4], tr_ba[4], C_ACT); end
    checks++; if (tr_cmd[7] !== C_RD || tr_addr[7] !== 15'h0123) begin errors++; $display("FAIL miss_cas: got %b %h want %b 0123", tr_cmd[7], tr_addr[7], C_RD); end
    checks++; if (tr_busy[8] !== 1'b1 || tr_busy[9] !== 1'b0) begin errors++; $display("FAIL miss_tccd: got busy %b%b want 10", tr_busy[8], tr_busy[9]); end
  endtask

  task automatic test_simultaneous();
    int ngnt;
    apply_reset();
    set_wr(3'd0, 15'h0111, 10'h001, 1'b0);
    set_rd(3'd1, 15'h0222, 10'h002, 1'b0);
    capture(3);
    set_wr(3'd0, 15'h0111, 10'h005, 1'b0);   // re-raised while busy
    capture(19);
    checks++; if (tr_wg[0] !== 1'b1 || tr_rg[0] !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b want 10", tr_wg[0], tr_rg[0]); end
    checks++; if (tr_rg[9] !== 1'b1 || tr_wg[9] !== 1'b0) begin errors++; $display("FAIL rr_second: got %b%b want 01", tr_wg[9], tr_rg[9]); end
    checks++; if (tr_wg[16] !== 1'b1 || tr_rg[16] !== 1'b0) begin errors++; $display("FAIL rr_third: got %b%b want 10", tr_wg[16], tr_rg[16]); end
    checks++; if (tr_cmd[13] !== C_RD || tr_ba[13] !== 3'd1 || tr_cmd[17] !== C_WR || tr_addr[17] !== 15'h0005) begin errors++; $display("FAIL rr_cas: got %b %0d %b %h want %b 1 %b 0005", tr_cmd[13], tr_ba[13], tr_cmd[17], tr_addr[17], C_RD, C_WR); end
    ngnt = 0;
    for (int i = 0; i < 22; i++) ngnt += int'(tr_wg[i]) + int'(tr_rg[i]);
    checks++; if (ngnt != 3) begin errors++; $display("FAIL rr_gnt_count: got %0d want 3", ngnt); end
  endtask

  task automatic test_auto_precharge();
    apply_reset();
    set_rd(3'd2, 15'h0444, 10'h3F8, 1'b1);
    capture(10);
    checks++; if (tr_cmd[4] !== C_RD || tr_addr[4] !== 15'h07F8 || tr_addr[4][10] !== 1'b1) begin errors++; $display("FAIL ap_cas: got %b %h want %b 07f8", tr_cmd[4], tr_addr[4], C_RD); end
    checks++; if (tr_busy[8] !== 1'b1 || tr_busy[9] !== 1'b0) begin errors++; $display("FAIL ap_recovery: got busy %b%b want 10", tr_busy[8], tr_busy[9]); end
    n_tr = 0;
    set_wr(3'd2, 15'h0444, 10'h011, 1'b0);
    capture(6);
    checks++; if (tr_cmd[1] !== C_ACT || tr_addr[1] !== 15'h0444 || tr_ba[1] !== 3'd2) begin errors++; $display("FAIL ap_reopen: got %b %h %0d want %b 0444 2", tr_cmd[1], tr_addr[1], tr_ba[1], C_ACT); end
    checks++; if (tr_cmd[4] !== C_WR) begin errors++; $display("FAIL ap_reopen_cas: got %b want %b", tr_cmd[4], C_WR); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bad;
    apply_reset();
    set_wr(3'd5, 15'h0555, 10'h055, 1'b0);
    capture(3);
    areset = 1'b1;
    capture(1);
    areset = 1'b0;
    capture(5);
    checks++; if (tr_cmd[1] !== C_ACT) begin errors++; $display("FAIL mid_act: got %b want %b", tr_cmd[1], C_ACT); end
    checks++; if (tr_cmd[3] !== C_NOP || tr_busy[3] !== 1'b0 || tr_addr[3] !== 15'h0 || tr_ba[3] !== 3'd0) begin errors++; $display("FAIL mid_reset: got %b %b %h %0d want %b 0 0 0", tr_cmd[3], tr_busy[3], tr_addr[3], tr_ba[3], C_NOP); end
    bad = 4'b0;
    for (int i = 4; i < 8; i++) if (tr_cmd[i] !== C_NOP || tr_busy[i] !== 1'b0) bad = tr_cmd[i];
    checks++; if (bad !== 4'b0) begin errors++; $display("FAIL mid_no_cas: got %b want only NOP", bad); end
    n_tr = 0;
    set_wr(3'd5, 15'h0555, 10'h066, 1'b0);
    capture(6);
    checks++; if (tr_cmd[1] !== C_ACT || tr_cmd[4] !== C_WR) begin errors++; $display("FAIL mid_table_cleared: got %b %b want %b %b", tr_cmd[1], tr_cmd[4], C_ACT, C_WR); end
  endtask

  task automatic rand_wr();
    set_wr(3'($urandom_range(7, 0)), 15'h0100 + 15'($urandom_range(2, 0)), 10'($urandom), ($urandom_range(3, 0) == 0));
  endtask

  task automatic rand_rd();
    set_rd(3'($urandom_range(7, 0)), 15'h0100 + 15'($urandom_range(2, 0)), 10'($urandom), ($urandom_range(3, 0) == 0));
  endtask

  // Transaction-level model: per grant, derive the command timeline from the
  // bank state (hit / miss / closed) and compare every cycle.
  task automatic test_random(input int n_txn);
    bit          m_open[8];
    logic [14:0] m_row[8];
    bit          m_last_rd, win_wr;
    logic [14:0] m_addr, row, e_mask;
    logic [2:0]  m_ba, b;
    logic [9:0]  col;
    logic        ap;
    logic [3:0]  e_cmd;
    logic [1:0]  pick;
    logic [24:0] got, expv;
    int          c_pre, c_act, c_cas, last;
    apply_reset();
    for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = 15'h0; end
    m_last_rd = 1'b1; m_addr = 15'h0; m_ba = 3'd0;
    for (int k = 0; k < n_txn; k++) begin
      if (!wr_req && !rd_req) begin
        pick = 2'($urandom_range(3, 1));
        if (pick[0]) rand_wr();
        if (pick[1]) rand_rd();
      end
      win_wr = wr_req && (!rd_req || m_last_rd);
      if (win_wr) begin b = wr_ba; row = wr_row; col = wr_col; ap = wr_ap; end
      else begin b = rd_ba; row = rd_row; col = rd_col; ap = rd_ap; end
      c_pre = -1; c_act = -1;
      if (m_open[b] && m_row[b] == row) c_cas = 1;
      else if (m_open[b]) begin c_pre = 1; c_act = 1 + T_RP; c_cas = c_act + T_RCD; end
      else begin c_act = 1; c_cas = 1 + T_RCD; end
      last = c_cas + (win_wr ? T_WR : T_CCD) + (ap ? T_RP : 0);
      for (int i = 0; i <= last; i++) begin
        @(negedge clk);
        e_cmd = C_NOP; e_mask = 15'h7FFF;
        if (i == c_pre) begin e_cmd = C_PRE; m_addr = 15'h0; m_ba = b; m_open[b] = 1'b0; end
        if (i == c_act) begin e_cmd = C_ACT; m_addr = row; m_ba = b; m_open[b] = 1'b1; m_row[b] = row; end
        if (i == c_cas) begin
          e_cmd = win_wr ? C_WR : C_RD; m_addr = {4'b0000, ap, col}; m_ba = b;
          if (ap) m_open[b] = 1'b0;
        end
        if (c_pre >= 0 && i >= c_pre && i < c_act) e_mask = 15'h0400;   // only A10 defined for PRE
        expv = {(i == 0) && win_wr, (i == 0) && !win_wr, i < last, e_cmd, m_ba, m_addr & e_mask};
        got  = {wr_gnt, rd_gnt, busy, CS_n, RAS_n, CAS_n, WE_n, BA_out, Addr_out & e_mask};
        checks++;
        if (got !== expv) begin errors++; $display("FAIL rand t%0d c%0d: got %h want %h", k, i, got, expv); end
        if (i == 0) begin
          if (win_wr) wr_req = 1'b0; else rd_req = 1'b0;
          m_last_rd = !win_wr;
        end else begin
          if (!wr_req && $urandom_range(3, 0) == 0) rand_wr();
          if (!rd_req && $urandom_range(3, 0) == 0) rand_rd();
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_row_hit();
    test_row_miss();
    test_simultaneous();
    test_auto_precharge();
    test_reset_mid();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
